// File: rtl/flow_pkg.sv
`default_nettype none
// ============================================================================
// flow_pkg : shared beat types and fixed-point constants for the flow pipeline
// Rev 1.0
// ============================================================================
package flow_pkg;

    localparam int FLOW_FRAC_BITS = 7;
    localparam int FLOW_PKG_WIDTH = 16;

    typedef struct packed {
        logic                             tuser;
        logic                             tlast;
        logic signed [FLOW_PKG_WIDTH-1:0] v;
        logic signed [FLOW_PKG_WIDTH-1:0] u;
    } flow_beat_t;

    // Frame-end marker rides alongside the beat so the output side needs no coordinates.
    typedef struct packed {
        logic       eof;
        flow_beat_t beat;
    } flow_entry_t;

endpackage
`default_nettype wire

// File: rtl/flow_axis_tx_if.sv
`default_nettype none
// ============================================================================
// flow_axis_tx_if : AXI4-Stream video-style bus (tdata/tvalid/tready/tlast/tuser)
// Rev 1.0
// ============================================================================
interface flow_axis_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/flow_sync_fifo.sv
`default_nettype none
// ============================================================================
// flow_sync_fifo : single-clock FIFO, fall-through read port, registered level
// Rev 1.0
// ============================================================================
module flow_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         wr_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [AW:0] C_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer MSB separates full (MSBs differ) from empty (all bits equal).
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + C_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + C_ONE;
                2'b01:   r_level <= r_level - C_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign level   = r_level;

endmodule
`default_nettype wire

// File: rtl/flow_axis_tx.sv
`default_nettype none
// ============================================================================
// flow_axis_tx : buffers solver flow samples and emits them as an AXI4-Stream
//                video stream; optional drop counter via FLOW_AXIS_TX_DROP_CNT_EN
// Rev 1.0
// ============================================================================
module flow_axis_tx
    import flow_pkg::*;
#(
    parameter int FLOW_WIDTH = FLOW_PKG_WIDTH,  // must equal the package beat width
    parameter int FIFO_DEPTH = 16,
    parameter int X_LAST     = 639,
    parameter int Y_LAST     = 479
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    input  wire logic signed [FLOW_WIDTH-1:0]    flow_u,
    input  wire logic signed [FLOW_WIDTH-1:0]    flow_v,
    input  wire logic                            flow_valid,
    input  wire logic        [9:0]               pixel_x_in,
    input  wire logic        [8:0]               pixel_y_in,
    flow_axis_tx_if.master                       m_axis,
    output logic                                 frame_done,
    output logic                                 overflow,
    input  wire logic                            clear_overflow,
`ifdef FLOW_AXIS_TX_DROP_CNT_EN
    output logic             [15:0]              drop_count,
`endif
    output logic             [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam logic [9:0] C_X_LAST = 10'(X_LAST);
    localparam logic [8:0] C_Y_LAST = 9'(Y_LAST);

    flow_entry_t w_wr_entry;
    flow_entry_t w_rd_entry;
    flow_entry_t r_out;
    logic        r_tvalid;
    logic        r_frame_done;
    logic        r_overflow;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_drop;
    logic        w_load;
    logic        w_handshake;

    // Framing is decided here, at input time, from the sample coordinates.
    always_comb begin
        w_wr_entry            = '0;
        w_wr_entry.beat.u     = flow_u;
        w_wr_entry.beat.v     = flow_v;
        w_wr_entry.beat.tuser = (pixel_x_in == 10'd0) && (pixel_y_in == 9'd0);
        w_wr_entry.beat.tlast = (pixel_x_in == C_X_LAST);
        w_wr_entry.eof        = (pixel_x_in == C_X_LAST) && (pixel_y_in == C_Y_LAST);
    end

    // A pop on the same edge never frees room for a beat that arrived while full.
    assign w_push      = flow_valid && !w_fifo_full;
    assign w_drop      = flow_valid &&  w_fifo_full;
    assign w_handshake = r_tvalid && m_axis.tready;
    assign w_load      = (!r_tvalid || m_axis.tready) && !w_fifo_empty;

    flow_sync_fifo #(
        .WIDTH (($bits(flow_entry_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (w_wr_entry),
        .pop     (w_load),
        .rd_data (w_rd_entry),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_tvalid <= 1'b0;
        end else if (w_load) begin
            r_out    <= w_rd_entry;
            r_tvalid <= 1'b1;
        end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_handshake && r_out.eof;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef FLOW_AXIS_TX_DROP_CNT_EN
    logic [15:0] r_drop_count;

    // A clear coinciding with a drop restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (clear_overflow) begin
            r_drop_count <= {15'd0, w_drop};
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign m_axis.tdata  = {r_out.beat.v, r_out.beat.u};
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_out.beat.tlast;
    assign m_axis.tuser  = r_out.beat.tuser;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_flow_axis_tx.sv
`default_nettype none
// ============================================================================
// tb_flow_axis_tx : randomized scoreboard bench for flow_axis_tx
// Rev 1.0
// ============================================================================
module tb_flow_axis_tx;
    import flow_pkg::*;

    localparam int DEPTH = 16;
    localparam int XL    = 3;
    localparam int YL    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] data;
        logic        tl;
        logic        tu;
        logic        eof;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] flow_u = '0;
    logic signed [15:0] flow_v = '0;
    logic               flow_valid = 1'b0;
    logic [9:0]         pixel_x = '0;
    logic [8:0]         pixel_y = '0;
    logic               clear_overflow = 1'b0;
    logic               frame_done;
    logic               overflow;
    logic [LW-1:0]      fifo_level;
`ifdef FLOW_AXIS_TX_DROP_CNT_EN
    logic [15:0]        drop_count;
`endif

    int total = 0;
    int bad   = 0;

    exp_t mdl_q[$];
    exp_t sb_q[$];
    bit   m_out  = 0;
    bit   m_ovf  = 0;
    bit   m_fd   = 0;
    int   m_fifo = 0;
    int   m_drops = 0;

    always #5 clk = ~clk;

    flow_axis_tx_if #(.DATA_WIDTH(32)) axis ();

    flow_axis_tx #(
        .FLOW_WIDTH (16),
        .FIFO_DEPTH (DEPTH),
        .X_LAST     (XL),
        .Y_LAST     (YL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flow_u         (flow_u),
        .flow_v         (flow_v),
        .flow_valid     (flow_valid),
        .pixel_x_in     (pixel_x),
        .pixel_y_in     (pixel_y),
        .m_axis         (axis),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
`ifdef FLOW_AXIS_TX_DROP_CNT_EN
        .drop_count     (drop_count),
`endif
        .fifo_level     (fifo_level)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pipeline is one ordered queue; the output slot holds its head.
    always @(posedge clk or negedge rst_n) begin
        int   fifo_before;
        bit   hs;
        bit   drop;
        exp_t e;
        if (!rst_n) begin
            mdl_q.delete();
            sb_q.delete();
            m_out = 0; m_ovf = 0; m_fd = 0; m_fifo = 0; m_drops = 0;
        end else begin
            fifo_before = mdl_q.size() - int'(m_out);
            hs          = m_out && axis.tready;
            drop        = flow_valid && (fifo_before == DEPTH);
            m_fd        = 0;
            if (hs) begin
                m_fd = mdl_q[0].eof;
                void'(mdl_q.pop_front());
            end
            m_out = (m_out && !hs) || (fifo_before > 0);
            if (flow_valid && !drop) begin
                e.data = {flow_v, flow_u};
                e.tu   = (pixel_x == 0) && (pixel_y == 0);
                e.tl   = (pixel_x == XL);
                e.eof  = (pixel_x == XL) && (pixel_y == YL);
                mdl_q.push_back(e);
                sb_q.push_back(e);
            end
            if (drop) m_ovf = 1;
            else if (clear_overflow) m_ovf = 0;
            if (clear_overflow) m_drops = drop ? 1 : 0;
            else if (drop && m_drops < 65535) m_drops++;
            m_fifo = mdl_q.size() - int'(m_out);
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks status each cycle.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_tl    = 1'b0;
    logic        prev_tu    = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            chk("tvalid", axis.tvalid, m_out);
            chk("fifo_level", fifo_level, m_fifo);
            chk("overflow", overflow, m_ovf);
            chk("frame_done", frame_done, m_fd);
`ifdef FLOW_AXIS_TX_DROP_CNT_EN
            chk("drop_count", drop_count, m_drops);
`endif
            if (prev_stall) begin
                chk("tdata_hold", axis.tdata, prev_data);
                chk("tlast_hold", axis.tlast, prev_tl);
                chk("tuser_hold", axis.tuser, prev_tu);
            end
            if (axis.tvalid && axis.tready) begin
                if (sb_q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("tdata", axis.tdata, e.data);
                    chk("tlast", axis.tlast, e.tl);
                    chk("tuser", axis.tuser, e.tu);
                end
            end
            prev_stall <= axis.tvalid && !axis.tready;
            prev_data  <= axis.tdata;
            prev_tl    <= axis.tlast;
            prev_tu    <= axis.tuser;
        end
    end

    task automatic drive_uv(input bit v, input logic [15:0] u, input logic [15:0] vv,
                            input int x, input int y, input bit rdy, input bit clr);
        @(posedge clk);
        #1;
        flow_valid     = v;
        flow_u         = u;
        flow_v         = vv;
        pixel_x        = 10'(x);
        pixel_y        = 9'(y);
        axis.tready    = rdy;
        clear_overflow = clr;
    endtask

    task automatic drive(input bit v, input bit rdy, input bit clr, input int x, input int y);
        drive_uv(v, 16'($urandom), 16'($urandom), x, y, rdy, clr);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, rdy, 0, 0, 0);
    endtask

    initial begin
        axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_tuser", axis.tuser, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single sample at frame origin
        drive_uv(1, 16'h0080, 16'hFF80, 0, 0, 1, 0);
        idle(4, 1);

        // one line at y=5
        for (int x = 0; x <= XL; x++) drive(1, 1, 0, x, 5);
        idle(4, 1);

        // backpressure: 20 samples into a 16+1 pipeline
        for (int i = 0; i < 20; i++) drive(1, 0, 0, i % (XL + 1), 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp_level", fifo_level, 16);
        chk("bp_overflow", overflow, 1);
        chk("bp_tvalid", axis.tvalid, 1);
        idle(25, 1);

        // full FIFO with a pop on the same edge as an incoming sample
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 17; i++) drive(1, 0, 0, i % (XL + 1), 2);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_pop_level", fifo_level, 15);
        chk("full_pop_overflow", overflow, 1);
        idle(25, 1);

        // overflow clear alone, then clear coinciding with a drop
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("clear_overflow", overflow, 0);
        for (int i = 0; i < 17; i++) drive(1, 0, 0, 1, 1);
        drive(1, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("clear_vs_drop", overflow, 1);
        idle(25, 1);
        drive(0, 1, 1, 0, 0);

        // randomized traffic with bursty backpressure
        for (int i = 0; i < 3000; i++) begin
            bit slow = ((i / 200) % 2) == 1;
            drive(($urandom % 4) != 0,
                  slow ? (($urandom % 4) == 0) : (($urandom % 3) != 0),
                  ($urandom % 60) == 0,
                  int'($urandom % (XL + 1)), int'($urandom % (YL + 1)));
        end
        idle(25, 1);

        // reset with eight entries buffered behind a valid output beat
        for (int i = 0; i < 9; i++) drive(1, 0, 0, 2, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        flow_valid = 1'b0;
        #1;
        chk("midrst_tvalid", axis.tvalid, 0);
        chk("midrst_level", fifo_level, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 1, 0, 0, 0);
        idle(4, 1);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) drive(0, 1, 0, 0, 0);
        chk("drain_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
